// File: rtl/loopback_pkg.sv
// Shared types and defaults for the loopback packet arbiter.
// The optional stall timeout is enabled with LOOPBACK_ARB_TIMEOUT_EN.
package loopback_pkg;

    localparam int LB_DATA_W = 8;
    localparam int LB_ERR_W  = 5;

    // Error code carried on the synthetic eop beat of an aborted frame.
    localparam logic [LB_ERR_W-1:0] LB_ABORT_ERR = 5'b10000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT0  = 2'd1,
        PKT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    // One-hot grant for a state; an aborting frame still belongs to its owner.
    function automatic logic [1:0] grant_of(input state_t s, input logic owner);
        case (s)
            PKT0:    grant_of = 2'b01;
            PKT1:    grant_of = 2'b10;
            ABORT:   grant_of = owner ? 2'b10 : 2'b01;
            default: grant_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/loopback_packet_arbiter_if.sv
// Avalon-ST beat bundle. The source drives it through master, the sink
// listens through slave.
interface loopback_packet_arbiter_if
    import loopback_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int ERR_W  = LB_ERR_W
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic [ERR_W-1:0]  error;

    modport master (
        output valid, data, startofpacket, endofpacket, error,
        input  ready
    );

    modport slave (
        input  valid, data, startofpacket, endofpacket, error,
        output ready
    );

endinterface

// File: rtl/loopback_arb_stall_timer.sv
// Counts consecutive cycles in which a granted packet makes no progress.
// Only instantiated when LOOPBACK_ARB_TIMEOUT_EN is defined.
module loopback_arb_stall_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic expire
);

    localparam int              CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Stall counter: restarts on any transfer or outside a packet.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (stall) begin
            count <= count + CNT_W'(1);
        end
    end

    // The owner is dropped on the cycle the count reaches its last value.
    assign expire = stall && (count == LAST);

endmodule

// File: rtl/loopback_packet_arbiter.sv
// Packet-granular 2:1 round-robin arbiter in front of the MAC loopback
// adapter. A grant is held from sop to eop so frames never interleave.
// Define LOOPBACK_ARB_TIMEOUT_EN to abort frames stalled for TIMEOUT cycles.
module loopback_packet_arbiter
    import loopback_pkg::*;
#(
    parameter int DATA_W  = LB_DATA_W,
    parameter int ERR_W   = LB_ERR_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    loopback_packet_arbiter_if.slave  in0,
    loopback_packet_arbiter_if.slave  in1,
    loopback_packet_arbiter_if.master out,
    output logic [1:0]              grant,
    output logic [15:0]             pkt_count0,
    output logic [15:0]             pkt_count1,
    output logic [7:0]              abort_count
);

    localparam logic [ERR_W-1:0] ABORT_CODE = {1'b1, {(ERR_W-1){1'b0}}};

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;   // 0: in0 owned last, 1: in1 owned last
    logic   pkt_xfer;
    logic   done0, done1;

    // A beat of the owning source moves downstream this cycle.
    assign pkt_xfer = ((state == PKT0) ? in0.valid :
                       (state == PKT1) ? in1.valid : 1'b0) && out.ready;

`ifdef LOOPBACK_ARB_TIMEOUT_EN
    logic in_pkt, stall, timer_clear, expire, abort_done;

    assign in_pkt      = (state == PKT0) || (state == PKT1);
    assign stall       = in_pkt && !pkt_xfer;
    assign timer_clear = !stall;

    loopback_arb_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .stall  (stall),
        .expire (expire)
    );
`endif

    // Arbitration, output mux and ready steering.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_nxt         = state;
        last_grant_nxt    = last_grant;
        done0             = 1'b0;
        done1             = 1'b0;
        in0.ready         = 1'b0;
        in1.ready         = 1'b0;
        out.valid         = 1'b0;
        out.data          = '0;
        out.startofpacket = 1'b0;
        out.endofpacket   = 1'b0;
        out.error         = '0;
`ifdef LOOPBACK_ARB_TIMEOUT_EN
        abort_done        = 1'b0;
`endif
        // Reset holds every output low, including the orphan-drop readies.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    // Sop beats wait for arbitration; anything else is orphaned and dropped.
                    in0.ready = !in0.startofpacket;
                    in1.ready = !in1.startofpacket;
                    if (in0.valid && in0.startofpacket &&
                        (!(in1.valid && in1.startofpacket) || last_grant)) begin
                        state_nxt      = PKT0;
                        last_grant_nxt = 1'b0;
                    end else if (in1.valid && in1.startofpacket) begin
                        state_nxt      = PKT1;
                        last_grant_nxt = 1'b1;
                    end
                end
                PKT0: begin
                    out.valid         = in0.valid;
                    out.data          = in0.data;
                    out.startofpacket = in0.startofpacket;
                    out.endofpacket   = in0.endofpacket;
                    out.error         = in0.error;
                    in0.ready         = out.ready;
                    if (pkt_xfer && in0.endofpacket) begin
                        state_nxt = IDLE;
                        done0     = 1'b1;
                    end
`ifdef LOOPBACK_ARB_TIMEOUT_EN
                    if (expire) state_nxt = ABORT;
`endif
                end
                PKT1: begin
                    out.valid         = in1.valid;
                    out.data          = in1.data;
                    out.startofpacket = in1.startofpacket;
                    out.endofpacket   = in1.endofpacket;
                    out.error         = in1.error;
                    in1.ready         = out.ready;
                    if (pkt_xfer && in1.endofpacket) begin
                        state_nxt = IDLE;
                        done1     = 1'b1;
                    end
`ifdef LOOPBACK_ARB_TIMEOUT_EN
                    if (expire) state_nxt = ABORT;
`endif
                end
`ifdef LOOPBACK_ARB_TIMEOUT_EN
                ABORT: begin
                    // Close the truncated frame with a flagged eop beat.
                    out.valid       = 1'b1;
                    out.endofpacket = 1'b1;
                    out.error       = ABORT_CODE;
                    if (out.ready) begin
                        state_nxt  = IDLE;
                        abort_done = 1'b1;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, owner history and registered grant.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 2'b00;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            grant      <= grant_of(state_nxt, last_grant_nxt);
        end
    end

    // Completed-frame counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count0 <= '0;
            pkt_count1 <= '0;
        end else begin
            if (done0) pkt_count0 <= pkt_count0 + 16'd1;
            if (done1) pkt_count1 <= pkt_count1 + 16'd1;
        end
    end

`ifdef LOOPBACK_ARB_TIMEOUT_EN
    // Aborted-frame counter, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            abort_count <= '0;
        end else if (abort_done && abort_count != 8'hFF) begin
            abort_count <= abort_count + 8'd1;
        end
    end
`else
    assign abort_count = 8'd0;
`endif

endmodule

// File: doc/loopback_packet_arbiter.md
# loopback_packet_arbiter

Packet-granular 2:1 Avalon-ST arbiter that shares the 8-bit MAC loopback path (loopback_adapter input) between two packet sources, e.g. the MAC TX stream and a testbench frame injector. It grants one source at a time and holds the grant from start-of-packet to end-of-packet, so frames never interleave. It alternates round-robin between competing sources and keeps per-source frame counters. Simulation/testbench-side block, synthesizable style.

## Interface
- DATA_W, 8, payload width per beat
- ERR_W, 5, error vector width (matches adapter in_error)
- TIMEOUT, 1024, stall cycles before a granted packet is aborted (used only with LOOPBACK_ARB_TIMEOUT_EN; ≥2)
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- in0_valid / in1_valid  in  1  source beat valid
- in0_ready / in1_ready  out  1  source beat accepted when valid&ready
- in0_data / in1_data  in  DATA_W  beat data
- in0_startofpacket, in0_endofpacket, in1_startofpacket, in1_endofpacket  in  1  framing
- in0_error / in1_error  in  ERR_W  per-beat error
- out_valid  out  1  to adapter in_valid
- out_ready  in  1  from adapter in_ready
- out_data  out  DATA_W; out_startofpacket, out_endofpacket  out  1; out_error  out  ERR_W
- grant  out  2  one-hot current owner (00 idle)
- pkt_count0 / pkt_count1  out  16  completed frames forwarded per source
- abort_count  out  8  aborted frames (0 without macro)

## Operation
- States: IDLE, PKT0, PKT1; ABORT added with macro.
- IDLE: outputs invalid. Candidate = source with valid&sop. Both candidates → pick the one not equal to last_grant; next cycle enter PKTx, last_grant←x. Non-sop beats presented in IDLE are accepted (ready=1) and discarded.
- PKTx: out_* = inx_* combinationally; inx_ready = out_ready; other source ready=0. Transfer = out_valid&out_ready. Transfer with eop → IDLE, pkt_countx+1 (16-bit wrap).
- Single-beat packet (sop&eop) counts as one frame.
- Sop arriving mid-packet from owner is forwarded unchanged (no checking).
- Reset: state IDLE, last_grant=1 (in0 wins first tie), all outputs 0, counters 0. Reset mid-packet truncates the frame; downstream sees no eop.

## Timing
- Arbitration latency: sop presented at cycle N → earliest acceptance N+1.
- Zero latency through mux during PKTx; no internal buffering.
- At least one IDLE cycle between consecutive packets.
- grant registered, equals state one-hot.
- Counters update the cycle after the eop transfer.

## Configuration
- LOOPBACK_ARB_TIMEOUT_EN defined: in PKTx, a stall counter increments each cycle without transfer and clears on transfer; when it reaches TIMEOUT-1 without transfer → ABORT. ABORT: inx_ready=0, drive out_valid=1, out_data=0, sop=0, eop=1, out_error=1<<(ERR_W-1); on out_ready → IDLE, abort_count+1 (saturate 255), pkt_count unchanged. Abandoned source's remaining beats are dropped by the IDLE non-sop rule.
- Undefined: no stall counter, no ABORT state, abort_count tied 0; a stalled owner holds grant indefinitely.

## Structure
- Shared package loopback_pkg: state enum (IDLE, PKT0, PKT1, ABORT), DATA_W/ERR_W defaults, abort error code constant.
- One natural sub-module: loopback_arb_stall_timer (counter, clear, expire), instantiated only under the macro.

## Test plan
- Single source: in0 sends 64-byte frame, out_ready=1 → first beat accepted 1 cycle after sop, 64 beats out intact, pkt_count0=1, grant returns 00.
- Contention: in0 and in1 sop same cycle after reset → in0 first, then in1; repeat → order alternates in1,in0; no interleave on out.
- Backpressure: out_ready toggled 1/0 each cycle during 10-byte in1 frame → in1_ready mirrors out_ready, in0_ready=0, data order preserved.
- Orphan beats: in1 valid without sop in IDLE, 3 beats → accepted and dropped, out_valid stays 0, counters unchanged.
- Reset mid-packet: assert reset at beat 5 of in0 frame → next cycle grant=00, out_valid=0, counters 0; new in1 frame then forwarded normally.
- Macro on, TIMEOUT=16: in0 stalls after beat 3 → 16 cycles later out shows eop beat with out_error=5'b10000, abort_count=1, pkt_count0=0.
